// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// supported opcodes and datapath mux/ALU select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: is_supported = 1'b1;
      default:                                       is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state-to-control decode. Reset forces every output low so an
// access in flight is abandoned without a write, pulse or PC update.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic       reset,
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op
);

  // Control decode: everything defaults low, each state raises only its own set.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    if (reset) begin
      instr_done = 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          if (!is_supported(opcode)) begin
            instr_done = 1'b1;
            illegal_op = 1'b1;
          end else begin
            illegal_op = 1'b0;
          end
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_RTYPEEX: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_RTYPEWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQEX: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_done    = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JEX: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        default: begin
          instr_done = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state logic, with the
// per-state control outputs produced by mc_output_decode.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t state;
  state_t next_state;

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: begin
        if (mem_ready) next_state = S_DECODE;
        else           next_state = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JEX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_SW) next_state = S_MEMWR;
        else                 next_state = S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) next_state = S_MEMWB;
        else           next_state = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready) next_state = S_FETCH;
        else           next_state = S_MEMWR;
      end
      S_RTYPEEX: next_state = S_RTYPEWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: next_state = S_FETCH;
      default:   next_state = S_FETCH;
    endcase
  end

  assign state_dbg = state;

  mc_output_decode u_decode (
    .reset         (reset),
    .state         (state),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus hand-written
// sequences for memory wait states, mid-instruction reset and latency.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state_dbg;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  // Packed control word: pw,pwc,iord,mr,mw,irw,m2r,rd,rw,asa,asb[2],aop[2],psrc[2],done,ill
  logic [17:0] act;
  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, illegal_op};

  function automatic logic [17:0] ctl(
    input logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa,
    input logic [1:0] asb, aop, psrc,
    input logic done, ill);
    ctl = {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AD = 6'b001000, JJ = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  logic [17:0] Z, F_RDY, F_WAIT, DEC, DEC_ILL, MADR, MRD, MWB, MWR_W, MWR_D;
  logic [17:0] RTEX, RTWB, BEQ, ADEX, ADWB, JEX;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] out;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [5:0] o, input logic y,
                              input logic [3:0] s, input logic [17:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = y; v.st = s; v.out = e;
    return v;
  endfunction

  // Drive one cycle's inputs, compare at the falling edge, then advance one clock.
  task automatic step(input logic r, input logic [5:0] o, input logic y,
                      input logic [3:0] s, input logic [17:0] e, input string name);
    reset = r; opcode = o; mem_ready = y;
    @(negedge clock);
    checks++;
    if (state_dbg !== s || act !== e)
      $display("FAIL %s: state=%0d ctl=%b, required state=%0d ctl=%b",
               name, state_dbg, act, s, e);
    else
      passed++;
    @(posedge clock); #1;
  endtask

  // Count cycles from FETCH through the instr_done pulse with mem_ready held 1.
  task automatic measure(input logic [5:0] o, input int exp_lat, input string name);
    int cnt = 0;
    bit seen = 1'b0;
    reset = 1'b0; opcode = o; mem_ready = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      cnt++;
      if (instr_done === 1'b1) seen = 1'b1;
      @(posedge clock); #1;
    end
    checks++;
    if (!seen || cnt != exp_lat)
      $display("FAIL latency_%s: cycles=%0d done_seen=%0d, required cycles=%0d",
               name, cnt, seen, exp_lat);
    else
      passed++;
  endtask

  initial begin
    Z       = '0;
    F_RDY   = ctl(1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    F_WAIT  = ctl(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    DEC     = ctl(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
    DEC_ILL = ctl(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 1,1);
    MADR    = ctl(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
    MRD     = ctl(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    MWB     = ctl(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
    MWR_W   = ctl(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    MWR_D   = ctl(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);
    RTEX    = ctl(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0);
    RTWB    = ctl(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 1,0);
    BEQ     = ctl(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0);
    ADEX    = ctl(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
    ADWB    = ctl(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
    JEX     = ctl(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1,0);

    // reset (first edge happens before the table), then release with mem_ready low
    vecs.push_back(mk(1, RT,  0, 4'd0,  Z));
    vecs.push_back(mk(1, RT,  1, 4'd0,  Z));
    vecs.push_back(mk(0, RT,  0, 4'd0,  F_WAIT));
    // lw; opcode wiggles in FETCH and MEMRD must be ignored
    vecs.push_back(mk(0, BAD, 1, 4'd0,  F_RDY));
    vecs.push_back(mk(0, LW,  1, 4'd1,  DEC));
    vecs.push_back(mk(0, LW,  1, 4'd2,  MADR));
    vecs.push_back(mk(0, SW,  1, 4'd3,  MRD));
    vecs.push_back(mk(0, LW,  1, 4'd4,  MWB));
    // R-type
    vecs.push_back(mk(0, RT,  1, 4'd0,  F_RDY));
    vecs.push_back(mk(0, RT,  1, 4'd1,  DEC));
    vecs.push_back(mk(0, RT,  1, 4'd6,  RTEX));
    vecs.push_back(mk(0, RT,  1, 4'd7,  RTWB));
    // addi
    vecs.push_back(mk(0, AD,  1, 4'd0,  F_RDY));
    vecs.push_back(mk(0, AD,  1, 4'd1,  DEC));
    vecs.push_back(mk(0, AD,  1, 4'd9,  ADEX));
    vecs.push_back(mk(0, AD,  1, 4'd10, ADWB));
    // beq then j back-to-back
    vecs.push_back(mk(0, BQ,  1, 4'd0,  F_RDY));
    vecs.push_back(mk(0, BQ,  1, 4'd1,  DEC));
    vecs.push_back(mk(0, BQ,  1, 4'd8,  BEQ));
    vecs.push_back(mk(0, JJ,  1, 4'd0,  F_RDY));
    vecs.push_back(mk(0, JJ,  1, 4'd1,  DEC));
    vecs.push_back(mk(0, JJ,  1, 4'd11, JEX));
    // illegal opcode
    vecs.push_back(mk(0, BAD, 1, 4'd0,  F_RDY));
    vecs.push_back(mk(0, BAD, 1, 4'd1,  DEC_ILL));
    vecs.push_back(mk(0, BAD, 0, 4'd0,  F_WAIT));

    reset = 1'b1; opcode = RT; mem_ready = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].out,
           $sformatf("vec%0d", i));

    // sw with three wait cycles in MEMWR
    step(0, SW, 1, 4'd0, F_RDY,  "sw_fetch");
    step(0, SW, 1, 4'd1, DEC,    "sw_decode");
    step(0, SW, 1, 4'd2, MADR,   "sw_memadr");
    step(0, SW, 0, 4'd5, MWR_W,  "sw_wait1");
    step(0, LW, 0, 4'd5, MWR_W,  "sw_wait2");
    step(0, SW, 0, 4'd5, MWR_W,  "sw_wait3");
    step(0, SW, 1, 4'd5, MWR_D,  "sw_done");
    step(0, SW, 0, 4'd0, F_WAIT, "sw_back_fetch");

    // reset during MEMRD wait, with mem_ready arriving in the same cycle
    step(0, LW, 1, 4'd0, F_RDY,  "rst_fetch");
    step(0, LW, 1, 4'd1, DEC,    "rst_decode");
    step(0, LW, 1, 4'd2, MADR,   "rst_memadr");
    step(0, LW, 0, 4'd3, MRD,    "rst_memrd_wait");
    step(1, LW, 1, 4'd3, Z,      "rst_memrd_reset");
    step(0, LW, 0, 4'd0, F_WAIT, "rst_after");

    // reset while MEMWR waits: no write or pulse
    step(0, SW, 1, 4'd0, F_RDY,  "rstw_fetch");
    step(0, SW, 1, 4'd1, DEC,    "rstw_decode");
    step(0, SW, 1, 4'd2, MADR,   "rstw_memadr");
    step(0, SW, 0, 4'd5, MWR_W,  "rstw_wait");
    step(1, SW, 1, 4'd5, Z,      "rstw_reset");
    step(0, SW, 0, 4'd0, F_WAIT, "rstw_after");

    measure(LW,  5, "lw");
    measure(SW,  4, "sw");
    measure(RT,  4, "rtype");
    measure(AD,  4, "addi");
    measure(BQ,  3, "beq");
    measure(JJ,  3, "j");
    measure(BAD, 2, "illegal");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have these ports:
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction register bits [31:26]
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address mux select, 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write-data mux, 0=ALUOut, 1=MDR
- reg_dst  out  1  destination mux, 0=rt, 1=rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm shifted left 2
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target {PC[31:28], imm26<<2}
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state_dbg  out  4  current state encoding

Function
REQ-002 Supported opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-003 The states and their encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-004 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write SHALL be 1 only in a cycle with mem_ready=1; on mem_ready=1 go to DECODE, else stay.
REQ-005 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute); next state SHALL be lw/sw->MEMADR, R->RTYPEEX, beq->BEQEX, addi->ADDIEX, j->JEX; any other opcode->FETCH with illegal_op=1 and instr_done=1 this cycle.
REQ-006 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state SHALL be MEMRD for lw and MEMWR for sw.
REQ-007 MEMRD: mem_read=1, i_or_d=1; on mem_ready=1 go to MEMWB, else stay.
REQ-008 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; next state SHALL be FETCH.
REQ-009 MEMWR: mem_write=1, i_or_d=1; stay until mem_ready=1, then instr_done=1 and go to FETCH.
REQ-010 RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10, next state RTYPEWB; RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1, next state FETCH.
REQ-011 BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1, next state FETCH.
REQ-012 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, next state ADDIWB; ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1, next state FETCH.
REQ-013 JEX: pc_write=1, pc_source=10, instr_done=1, next state FETCH.
REQ-014 Any output not listed for a state SHALL be 0; mem_read and mem_write SHALL never be 1 together.
REQ-015 Opcode SHALL be sampled only in DECODE and MEMADR; changes elsewhere SHALL have no effect.
REQ-016 Instruction latency with mem_ready tied 1 SHALL be: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2 cycles.
REQ-017 Unreachable state encodings 12-15 SHALL transition to FETCH with all control outputs 0.

Reset
REQ-018 While reset=1, all control outputs, instr_done and illegal_op SHALL be 0, and the state SHALL become FETCH on the next rising edge regardless of current state or pending mem_ready.
REQ-019 A reset asserted mid-instruction (e.g. MEMWR waiting on mem_ready) SHALL abandon the access with no write, pulse or PC update issued.

Structure
REQ-020 The state enum, opcode constants and alu_op/alu_src_b/pc_source encodings SHALL live in shared package mips_ctrl_pkg.
REQ-021 State-to-control decoding SHALL be one combinational sub-module, mc_output_decode; state register and next-state logic SHALL stay in multicycle_control.

Verification
REQ-022 Reset held 3 cycles then released with mem_ready=0 -> state_dbg=0, all outputs 0 during reset; mem_read=1, pc_write=0 afterwards.
REQ-023 lw (100011), mem_ready=1 -> state_dbg 0,1,2,3,4; reg_write=1, mem_to_reg=1 in cycle 5; instr_done single pulse.
REQ-024 sw with mem_ready low 3 cycles in MEMWR -> mem_write=1 for 4 cycles, instr_done only on the cycle mem_ready=1.
REQ-025 beq then j back-to-back -> pc_write_cond=1, pc_source=01 in BEQEX; pc_write=1, pc_source=10 in JEX; 3 cycles each.
REQ-026 opcode 111111 in DECODE -> illegal_op=1 and instr_done=1 for one cycle, next state_dbg=0.
REQ-027 reset pulsed during MEMRD wait -> no MEMWB, reg_write never 1, state_dbg=0 next cycle.
